alu_instr_sequencer: RTL

- Parametrised control sequencer for the Mini SRC datapath.
- Runs a full instruction fetch followed by execution of one register ALU instruction: binary, unary, or wide (MUL/DIV into HI/LO).
- Drives the datapath's bus-select, register-enable, ALU-op, PC-increment and memory-read controls, which were previously hand-driven one T-state at a time.
- Adds a start/done handshake, a variable-latency memory fetch, per-class state skipping and illegal-opcode detection.

---
 rtl/alu_seq_pkg.sv | 86 ++++++++
 rtl/instr_class_decode.sv | 20 ++
 rtl/alu_instr_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared states, instruction classes, opcodes and
// datapath select/ALU constants for the Mini SRC ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_DEC,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    CLS_BIN,
    CLS_UN,
    CLS_WIDE,
    CLS_ILL
  } cls_e;

  localparam logic [4:0] OPC_ADD = 5'd0;
  localparam logic [4:0] OPC_SUB = 5'd1;
  localparam logic [4:0] OPC_AND = 5'd2;
  localparam logic [4:0] OPC_OR  = 5'd3;
  localparam logic [4:0] OPC_SHR = 5'd4;
  localparam logic [4:0] OPC_SHL = 5'd5;
  localparam logic [4:0] OPC_ROR = 5'd6;
  localparam logic [4:0] OPC_ROL = 5'd7;
  localparam logic [4:0] OPC_MUL = 5'd8;
  localparam logic [4:0] OPC_DIV = 5'd9;
  localparam logic [4:0] OPC_NEG = 5'd10;
  localparam logic [4:0] OPC_NOT = 5'd11;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SHR = 4'b0100;
  localparam logic [3:0] ALU_SHL = 4'b0101;
  localparam logic [3:0] ALU_ROR = 4'b0110;
  localparam logic [3:0] ALU_ROL = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_DIV = 4'b1001;
  localparam logic [3:0] ALU_NOT = 4'b1010;
  localparam logic [3:0] ALU_NEG = 4'b1011;

  localparam logic [4:0] SEL_GP  = 5'b00000;
  localparam logic [4:0] SEL_ZHI = 5'b10010;
  localparam logic [4:0] SEL_ZLO = 5'b10011;
  localparam logic [4:0] SEL_PC  = 5'b10100;
  localparam logic [4:0] SEL_MDR = 5'b10101;

  typedef struct packed {
    cls_e       cls;
    logic [3:0] alu_op;
  } dec_t;

  function automatic dec_t decode_opc(
    input logic [4:0] opc
  );
    dec_t d;
    d.cls    = CLS_ILL;
    d.alu_op = 4'b0000;
    unique case (opc)
      OPC_ADD: d = '{CLS_BIN, ALU_ADD};
      OPC_SUB: d = '{CLS_BIN, ALU_SUB};
      OPC_AND: d = '{CLS_BIN, ALU_AND};
      OPC_OR:  d = '{CLS_BIN, ALU_OR};
      OPC_SHR: d = '{CLS_BIN, ALU_SHR};
      OPC_SHL: d = '{CLS_BIN, ALU_SHL};
      OPC_ROR: d = '{CLS_BIN, ALU_ROR};
      OPC_ROL: d = '{CLS_BIN, ALU_ROL};
      OPC_MUL: d = '{CLS_WIDE, ALU_MUL};
      OPC_DIV: d = '{CLS_WIDE, ALU_DIV};
      OPC_NEG: d = '{CLS_UN, ALU_NEG};
      OPC_NOT: d = '{CLS_UN, ALU_NOT};
      default: d = '{CLS_ILL, 4'b0000};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: combinational opcode -> class and ALU op.
// Undefined opcodes report CLS_ILL with a zero ALU op.
module instr_class_decode
  import alu_seq_pkg::*;
#(
  parameter int OPC_W    = 5,
  parameter int ALU_OP_W = 4
) (
  input  logic [OPC_W-1:0]    i_opc,
  output cls_e                o_cls,
  output logic [ALU_OP_W-1:0] o_alu_op
);

  dec_t w_dec;

  assign w_dec    = decode_opc(5'(i_opc));
  assign o_cls    = w_dec.cls;
  assign o_alu_op = ALU_OP_W'(w_dec.alu_op);

endmodule

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: Mini SRC fetch + one register ALU instruction.
// Define SEQ_SINGLE_STEP_EN to add the step input for single-stepping.
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NREG     = 16,
  parameter int OPC_W    = 5,
  parameter int ALU_OP_W = 4,
  parameter int SEL_W    = 5,
  localparam int REG_W   = $clog2(NREG)
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic                busy,
  output logic                done,
  output logic                illegal,
  input  logic [DATA_W-1:0]   ir_in,
  input  logic                mem_ack,
  output logic                MDR_read,
  output logic [SEL_W-1:0]    BusDataSelect,
  output logic [REG_W-1:0]    GP_addr,
  output logic                e_PC,
  output logic                e_IR,
  output logic                e_Y,
  output logic                e_Z,
  output logic                e_HI,
  output logic                e_LO,
  output logic                e_MDR,
  output logic                e_MAR,
  output logic                e_GP,
  output logic                incPC,
  output logic [ALU_OP_W-1:0] alu_op
);

  localparam int RA_HI = 31 - OPC_W;
  localparam int RB_HI = RA_HI - REG_W;
  localparam int RC_HI = RB_HI - REG_W;
  localparam int LO_HI = RC_HI - REG_W;

  state_e              r_state;
  state_e              w_nxt;
  cls_e                r_cls;
  cls_e                w_cls;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic [ALU_OP_W-1:0] w_alu_op;
  logic [REG_W-1:0]    r_ra;
  logic [REG_W-1:0]    r_rb;
  logic [REG_W-1:0]    r_rc;
  logic                r_illegal;
  logic                w_step;
  logic                w_unused_ir;

`ifdef SEQ_SINGLE_STEP_EN
  assign w_step = step;
`else
  assign w_step = 1'b1;
`endif

  assign w_unused_ir = ^ir_in[LO_HI:0];

  instr_class_decode #(
    .OPC_W    (OPC_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_dec (
    .i_opc    (ir_in[31 -: OPC_W]),
    .o_cls    (w_cls),
    .o_alu_op (w_alu_op)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state   <= S_IDLE;
      r_cls     <= CLS_BIN;
      r_alu_op  <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_rc      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_DEC && w_step) begin
        r_cls     <= w_cls;
        r_alu_op  <= w_alu_op;
        r_ra      <= ir_in[RA_HI -: REG_W];
        r_rb      <= ir_in[RB_HI -: REG_W];
        r_rc      <= ir_in[RC_HI -: REG_W];
        r_illegal <= (w_cls == CLS_ILL);
      end
    end
  end

  always_comb begin
    w_nxt         = r_state;
    busy          = (r_state != S_IDLE);
    done          = 1'b0;
    illegal       = 1'b0;
    MDR_read      = 1'b0;
    BusDataSelect = '0;
    GP_addr       = '0;
    e_PC          = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    e_HI          = 1'b0;
    e_LO          = 1'b0;
    e_MDR         = 1'b0;
    e_MAR         = 1'b0;
    e_GP          = 1'b0;
    incPC         = 1'b0;
    alu_op        = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_nxt = S_T0;
      end
      S_T0: begin
        BusDataSelect = SEL_W'(SEL_PC);
        e_MAR         = w_step;
        incPC         = w_step;
        e_Z           = w_step;
        if (w_step) w_nxt = S_T1;
      end
      S_T1: begin
        BusDataSelect = SEL_W'(SEL_ZLO);
        e_PC          = w_step;
        MDR_read      = w_step;
        e_MDR         = w_step;
        if (w_step && mem_ack) w_nxt = S_T2;
      end
      S_T2: begin
        BusDataSelect = SEL_W'(SEL_MDR);
        e_IR          = w_step;
        if (w_step) w_nxt = S_DEC;
      end
      S_DEC: begin
        if (w_step) begin
          unique case (w_cls)
            CLS_BIN, CLS_WIDE: w_nxt = S_T3;
            CLS_UN:            w_nxt = S_T4;
            default:           w_nxt = S_DONE;
          endcase
        end
      end
      S_T3: begin
        BusDataSelect = SEL_W'(SEL_GP);
        GP_addr       = r_rb;
        e_Y           = w_step;
        alu_op        = r_alu_op;
        if (w_step) w_nxt = S_T4;
      end
      S_T4: begin
        BusDataSelect = SEL_W'(SEL_GP);
        GP_addr       = (r_cls == CLS_UN) ? r_rb : r_rc;
        e_Z           = w_step;
        alu_op        = r_alu_op;
        if (w_step) w_nxt = S_T5;
      end
      S_T5: begin
        BusDataSelect = SEL_W'(SEL_ZLO);
        alu_op        = r_alu_op;
        if (r_cls == CLS_WIDE) begin
          e_LO = w_step;
          if (w_step) w_nxt = S_T6;
        end else begin
          GP_addr = r_ra;
          e_GP    = w_step;
          if (w_step) w_nxt = S_DONE;
        end
      end
      S_T6: begin
        BusDataSelect = SEL_W'(SEL_ZHI);
        e_HI          = w_step;
        alu_op        = r_alu_op;
        if (w_step) w_nxt = S_DONE;
      end
      S_DONE: begin
        // done is gated so a held DONE still yields one pulse
        done    = w_step;
        illegal = w_step & r_illegal;
        alu_op  = r_alu_op;
        if (w_step) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

endmodule
